// File: rtl/tpu_pkg.sv
// Shared definitions for tpu_job_ctrl: FSM state encoding, TPU address map
// and the helpers that turn a word index into a TPU address.
package tpu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_CLEAR   = 3'd2;
    localparam state_t ST_START   = 3'd3;
    localparam state_t ST_COMPUTE = 3'd4;
    localparam state_t ST_READ    = 3'd5;
    localparam state_t ST_HOLD    = 3'd6;
    localparam state_t ST_DONE    = 3'd7;

    localparam logic [15:0] A_BASE     = 16'h0100;
    localparam logic [15:0] B_BASE     = 16'h0200;
    localparam logic [15:0] C_BASE     = 16'h0300;
    localparam logic [15:0] START_ADDR = 16'h0400;

    // Stream order is A rows, B rows, then C half-rows, each 8 bytes apart.
    function automatic logic [15:0] load_addr(input int k, input int dim);
        if (k < dim)
            return A_BASE + 16'(8 * k);
        else if (k < 2 * dim)
            return B_BASE + 16'(8 * (k - dim));
        else
            return C_BASE + 16'(8 * (k - 2 * dim));
    endfunction

    function automatic logic [15:0] c_addr(input int j);
        return C_BASE + 16'(8 * j);
    endfunction

endpackage

// File: rtl/tpu_wait_cnt.sv
// Loadable down-counter with a zero flag; times the systolic compute window.
module tpu_wait_cnt #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tpu_job_ctrl.sv
// Job sequencer for the tpuv1 bus: load operands, start, wait, read C back.
// TPU_JOB_CTRL_CLEAR_C_EN: stream carries only A/B; C is zero-filled here.
//
// state   | meaning
// IDLE    | waiting for job_start
// LOAD    | accepting operand words, each written to the TPU one cycle later
// CLEAR   | writing zero C half-rows (TPU_JOB_CTRL_CLEAR_C_EN only)
// START   | issuing the single 0x400 start write
// COMPUTE | bus idle while the array computes
// READ    | one read cycle of a C half-row, captured at cycle end
// HOLD    | presenting the captured word until out_ready
// DONE    | one-cycle done pulse
module tpu_job_ctrl
    import tpu_pkg::*;
#(
    parameter int DIM   = 8,
    parameter int DATAW = 64,
    parameter int ADDRW = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             job_start_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DATAW-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DATAW-1:0] out_data_o,
    output logic             tpu_r_w_o,
    output logic [ADDRW-1:0] tpu_addr_o,
    output logic [DATAW-1:0] tpu_din_o,
    input  logic [DATAW-1:0] tpu_dout_i
);

    localparam int WAIT_CYC = 3 * DIM - 1;
    localparam int WW       = $clog2(WAIT_CYC + 1);
    localparam int KW       = $clog2(4 * DIM) + 1;
`ifdef TPU_JOB_CTRL_CLEAR_C_EN
    localparam int N_STREAM = 2 * DIM;
`else
    localparam int N_STREAM = 4 * DIM;
`endif

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               out_valid_q, out_valid_d;
    logic [DATAW-1:0]   out_data_q, out_data_d;
    logic               r_w_q, r_w_d;
    logic [ADDRW-1:0]   addr_q, addr_d;
    logic [DATAW-1:0]   din_q, din_d;
    logic               wait_load, wait_en, wait_zero;

    tpu_wait_cnt #(.W(WW)) u_wait_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wait_load),
        .load_val_i (WW'(WAIT_CYC)),
        .en_i       (wait_en),
        .zero_o     (wait_zero)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        r_w_d       = 1'b0;
        addr_d      = '0;
        din_d       = '0;
        wait_load   = 1'b0;
        wait_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (job_start_i) begin
                    state_d = ST_LOAD;
                    k_d     = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid_i) begin
                    r_w_d  = 1'b1;
                    addr_d = ADDRW'(load_addr(32'(k_q), DIM));
                    din_d  = in_data_i;
                    k_d    = k_q + KW'(1);
                    if (k_q == KW'(N_STREAM - 1)) begin
`ifdef TPU_JOB_CTRL_CLEAR_C_EN
                        state_d = ST_CLEAR;
`else
                        state_d = ST_START;
`endif
                    end
                end
            end
            ST_CLEAR: begin
                r_w_d  = 1'b1;
                addr_d = ADDRW'(load_addr(32'(k_q), DIM));
                k_d    = k_q + KW'(1);
                if (k_q == KW'(4 * DIM - 1))
                    state_d = ST_START;
            end
            ST_START: begin
                // Registered here so 0x400 appears on the bus for exactly one cycle.
                r_w_d     = 1'b1;
                addr_d    = ADDRW'(START_ADDR);
                wait_load = 1'b1;
                state_d   = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (wait_zero) begin
                    state_d = ST_READ;
                    k_d     = '0;
                    addr_d  = ADDRW'(c_addr(0));
                end else begin
                    wait_en = 1'b1;
                end
            end
            ST_READ: begin
                out_data_d  = tpu_dout_i;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    k_d         = k_q + KW'(1);
                    if (k_q == KW'(2 * DIM - 1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        addr_d  = ADDRW'(c_addr(32'(k_q) + 1));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            r_w_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            r_w_q       <= r_w_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign in_ready_o  = (state_q == ST_LOAD);
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign tpu_r_w_o   = r_w_q;
    assign tpu_addr_o  = addr_q;
    assign tpu_din_o   = din_q;

endmodule

// File: tb/tb_tpu_job_ctrl.sv
// Randomized bench for tpu_job_ctrl with a behavioural TPU and a matrix reference model.
module tb_tpu_job_ctrl;

    localparam int DIM      = 8;
    localparam int DATAW    = 64;
    localparam int ADDRW    = 16;
    localparam int WAIT_CYC = 3 * DIM - 1;
`ifdef TPU_JOB_CTRL_CLEAR_C_EN
    localparam int NSTREAM  = 2 * DIM;
    localparam bit CLEAR_C  = 1'b1;
`else
    localparam int NSTREAM  = 4 * DIM;
    localparam bit CLEAR_C  = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             job_start, busy, done;
    logic             in_valid, in_ready;
    logic [DATAW-1:0] in_data;
    logic             out_valid, out_ready;
    logic [DATAW-1:0] out_data;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_din, tpu_dout;

    always #5 clk = ~clk;

    tpu_job_ctrl #(.DIM(DIM), .DATAW(DATAW), .ADDRW(ADDRW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .job_start_i (job_start),
        .busy_o      (busy),
        .done_o      (done),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .tpu_r_w_o   (tpu_r_w),
        .tpu_addr_o  (tpu_addr),
        .tpu_din_o   (tpu_din),
        .tpu_dout_i  (tpu_dout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural TPU: 8-bit signed A/B elements, 16-bit C, C += A*B on start.
    logic [63:0] ta [8];
    logic [63:0] tbm[8];
    logic [63:0] tc [16];

    always @(posedge clk) begin
        int a, s;
        logic [63:0] w;
        a = int'(tpu_addr);
        if (tpu_r_w) begin
            if (a >= 'h100 && a < 'h140) ta[(a - 'h100) / 8] <= tpu_din;
            else if (a >= 'h200 && a < 'h240) tbm[(a - 'h200) / 8] <= tpu_din;
            else if (a >= 'h300 && a < 'h380) tc[(a - 'h300) / 8] <= tpu_din;
            else if (a == 'h400) begin
                for (int r = 0; r < 8; r++)
                    for (int h = 0; h < 2; h++) begin
                        w = tc[2*r+h];
                        for (int e = 0; e < 4; e++) begin
                            s = 0;
                            for (int k = 0; k < 8; k++)
                                s += int'($signed(ta[r][8*k +: 8])) * int'($signed(tbm[k][8*(4*h+e) +: 8]));
                            w[16*e +: 16] = w[16*e +: 16] + 16'(s);
                        end
                        tc[2*r+h] <= w;
                    end
            end
        end
    end

    always_comb begin
        tpu_dout = '0;
        if (int'(tpu_addr) >= 'h300 && int'(tpu_addr) < 'h380)
            tpu_dout = tc[(int'(tpu_addr) - 'h300) / 8];
    end

    // Bus monitor
    int          cyc_g = 0;
    int          wr_c[$], rd_c[$], acc_q[$];
    logic [15:0] wr_a[$], rd_a[$];
    logic [63:0] wr_d[$];
    int          start_cnt, start_cyc, done_cnt;
    bit          job_over;

    always @(posedge clk) cyc_g <= cyc_g + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (tpu_addr == 16'h0400) begin
                start_cnt++;
                start_cyc = cyc_g;
            end else if (tpu_r_w) begin
                wr_a.push_back(tpu_addr);
                wr_d.push_back(tpu_din);
                wr_c.push_back(cyc_g);
            end else if (tpu_addr != '0) begin
                rd_a.push_back(tpu_addr);
                rd_c.push_back(cyc_g);
            end
            if (done) done_cnt++;
        end
    end

    // Reference model: matrices as integers, words packed from them.
    int          Ae[8][8], Be[8][8], Ce[8][8];
    logic [63:0] words[$];
    logic [63:0] expw[16];

    task automatic build_job(input bit ident);
        logic [63:0] w;
        int v;
        words.delete();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                Ae[i][j] = ident ? int'(i == j) : int'($urandom_range(0, 255)) - 128;
                Be[i][j] = ident ? i + j : int'($urandom_range(0, 255)) - 128;
                Ce[i][j] = (ident || CLEAR_C) ? 0 : int'($urandom_range(0, 65535)) - 32768;
            end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(Ae[i][j]);
            words.push_back(w);
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(Be[i][j]);
            words.push_back(w);
        end
        if (!CLEAR_C)
            for (int q = 0; q < 16; q++) begin
                for (int e = 0; e < 4; e++) w[16*e +: 16] = 16'(Ce[q/2][4*(q%2)+e]);
                words.push_back(w);
            end
        for (int q = 0; q < 16; q++) begin
            for (int e = 0; e < 4; e++) begin
                v = Ce[q/2][4*(q%2)+e];
                for (int k = 0; k < 8; k++) v += Ae[q/2][k] * Be[k][4*(q%2)+e];
                w[16*e +: 16] = 16'(v);
            end
            expw[q] = w;
        end
    endtask

    task automatic clear_logs();
        wr_c.delete(); rd_c.delete(); acc_q.delete();
        wr_a.delete(); rd_a.delete(); wr_d.delete();
        start_cnt = 0; start_cyc = 0; done_cnt = 0; job_over = 1'b0;
    endtask

    task automatic drive_words(input bit gap);
        int  i = 0;
        int  t = 0;
        bit  acc;
        while (i < words.size() && t < 1000) begin
            @(negedge clk);
            t++;
            in_valid = gap ? cyc_g[0] : 1'b1;
            in_data  = words[i];
            acc      = in_valid && in_ready;
            if (acc) acc_q.push_back(cyc_g);
            @(posedge clk);
            if (acc) i++;
        end
        chk("drv_accepted", i, words.size());
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
    endtask

    task automatic recv(input bit bp);
        int n = 0;
        int t = 0;
        int stall = 0;
        bit hs;
        while (n < 16 && t < 3000) begin
            @(negedge clk);
            t++;
            hs = 1'b0;
            if (out_valid) begin
                if (bp && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                    chk("out_hold", out_data, expw[n]);
                end else begin
                    out_ready = 1'b1;
                    hs = 1'b1;
                    stall = 0;
                    chk("out_data", out_data, expw[n]);
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            if (hs) n++;
        end
        chk("recv_cnt", n, 16);
        @(negedge clk);
        out_ready = 1'b0;
        job_over  = 1'b1;
    endtask

    task automatic spur_drive(input bit spur);
        int t = 0;
        @(negedge clk);
        job_start = 1'b0;
        while (!job_over && t < 5000) begin
            @(negedge clk);
            t++;
            job_start = spur && busy && ($urandom_range(0, 3) == 0);
        end
        job_start = 1'b0;
    endtask

    task automatic check_bus(input bit gap);
        int exp_a;
        chk("wr_cnt", wr_a.size(), 4 * DIM);
        for (int i = 0; i < wr_a.size() && i < 4 * DIM; i++) begin
            exp_a = (i < 8) ? 'h100 + 8*i : (i < 16) ? 'h200 + 8*(i-8) : 'h300 + 8*(i-16);
            chk("wr_addr", wr_a[i], exp_a);
            chk("wr_data", wr_d[i], (i < NSTREAM) ? words[i] : 64'd0);
        end
        for (int i = 0; i < NSTREAM && i < acc_q.size() && i < wr_c.size(); i++)
            chk("wr_latency", wr_c[i], acc_q[i] + 1);
        chk("start_cnt", start_cnt, 1);
        if (wr_c.size() == 4 * DIM) begin
            if (!gap) chk("wr_contiguous", wr_c[4*DIM-1] - wr_c[0], 4 * DIM - 1);
            chk("start_after_wr", start_cyc, wr_c[4*DIM-1] + 1);
        end
        chk("rd_cnt", rd_a.size(), 16);
        for (int i = 0; i < rd_a.size() && i < 16; i++)
            chk("rd_addr", rd_a[i], 'h300 + 8*i);
        if (rd_c.size() > 0) chk("rd_first", rd_c[0], start_cyc + WAIT_CYC + 1);
    endtask

    task automatic run_job(input bit ident, input bit gap, input bit bp, input bit spur);
        build_job(ident);
        @(posedge clk);
        clear_logs();
        @(negedge clk);
        job_start = 1'b1;
        fork
            drive_words(gap);
            recv(bp);
            spur_drive(spur);
        join
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("done_cnt", done_cnt, 1);
        chk("busy_end", busy, 1'b0);
        check_bus(gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      busy,      1'b0);
        chk({tag, "_done"},      done,      1'b0);
        chk({tag, "_in_ready"},  in_ready,  1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"},  out_data,  64'd0);
        chk({tag, "_tpu_r_w"},   tpu_r_w,   1'b0);
        chk({tag, "_tpu_addr"},  tpu_addr,  16'd0);
        chk({tag, "_tpu_din"},   tpu_din,   64'd0);
    endtask

    task automatic abort_job();
        int t = 0;
        build_job(1'b0);
        @(posedge clk);
        clear_logs();
        @(negedge clk);
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        drive_words(1'b0);
        in_valid = 1'b0;
        while (start_cnt == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("abort_start_seen", start_cnt, 1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        check_reset_outputs("abort_held");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_idle_busy", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        job_start = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_job(1'b1, 1'b0, 1'b0, 1'b0);
        run_job(1'b0, 1'b1, 1'b0, 1'b0);
        run_job(1'b0, 1'b0, 1'b1, 1'b0);
        run_job(1'b0, 1'b1, 1'b0, 1'b1);
        abort_job();
        run_job(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            run_job(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
